// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Each stage adds one WIDTH/STAGES slice; upper operand slices travel in skew registers.
module cla_pipe #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int NG   = SW / GROUP;
  localparam int LAST = STAGES - 1;

  // *_d: stage inputs, *_n: stage results, *_q: stage registers
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] s_n [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_d [STAGES];
  logic             c_n [STAGES];
  logic             c_q [STAGES];
  logic             v_d [STAGES];
  logic             v_q [STAGES];

  logic msb_cin;
  logic cout_q;
  logic ovf_q;
  logic zero_q;
  logic adv;

  assign adv       = out_ready | ~v_q[LAST];
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * SW;
      localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << LO;

      logic [SW-1:0] sp;
      logic [SW-1:0] sg;
      logic [SW-1:0] sc;
      logic [SW-1:0] ssum;
      logic [NG:0]   gc;
      logic          gp_grp;
      logic          gg_grp;

      if (gi == 0) begin : g_src
        assign a_d[gi] = a;
        assign b_d[gi] = sub ? ~b : b;
        assign c_d[gi] = sub | cin;
        assign s_d[gi] = '0;
        assign v_d[gi] = in_valid & adv;
      end else begin : g_chain
        assign a_d[gi] = a_q[gi-1];
        assign b_d[gi] = b_q[gi-1];
        assign c_d[gi] = c_q[gi-1];
        assign s_d[gi] = s_q[gi-1];
        assign v_d[gi] = v_q[gi-1];
      end

      // Group P/G by lookahead; group carries ripple across the slice
      always_comb begin
        sp     = a_d[gi][LO +: SW] ^ b_d[gi][LO +: SW];
        sg     = a_d[gi][LO +: SW] & b_d[gi][LO +: SW];
        gc     = '0;
        gc[0]  = c_d[gi];
        sc     = '0;
        gp_grp = 1'b0;
        gg_grp = 1'b0;
        for (int g = 0; g < NG; g++) begin
          gp_grp = &sp[g*GROUP +: GROUP];
          gg_grp = 1'b0;
          for (int i = 0; i < GROUP; i++)
            gg_grp = sg[g*GROUP+i] | (sp[g*GROUP+i] & gg_grp);
          sc[g*GROUP] = gc[g];
          for (int i = 1; i < GROUP; i++)
            sc[g*GROUP+i] = sg[g*GROUP+i-1] | (sp[g*GROUP+i-1] & sc[g*GROUP+i-1]);
          gc[g+1] = gg_grp | (gp_grp & gc[g]);
        end
        ssum = sp ^ sc;
      end

      assign s_n[gi] = (s_d[gi] & ~MASK) | (WIDTH'(ssum) << LO);
      assign c_n[gi] = gc[NG];

      if (gi == LAST) begin : g_flag
        assign msb_cin = sc[SW-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
      end
      cout_q <= c_n[LAST];
      ovf_q  <= msb_cin ^ c_n[LAST];
      zero_q <= ~|s_n[LAST];
    end
  end

endmodule

// File: tb/tb_cla_pipe.sv
// Directed checks of cla_pipe (16/4/2) plus a random sweep of three other configurations.
module tb_cla_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;

  logic        v1, r1, c1i, s1i, ov1, or1, co1, of1, z1;
  logic [15:0] a1, b1, s1;
  logic        v4, r4, c4i, s4i, ov4, or4, co4, of4, z4;
  logic [31:0] a4, b4, s4;
  logic        v8, r8, c8i, s8i, ov8, or8, co8, of8, z8;
  logic [63:0] a8, b8, s8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  cla_pipe #(.WIDTH(16), .GROUP(4), .STAGES(1)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
    .cin(c1i), .sub(s1i), .out_valid(ov1), .out_ready(or1), .sum(s1),
    .cout(co1), .ovf(of1), .zero(z1));

  cla_pipe #(.WIDTH(32), .GROUP(4), .STAGES(4)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
    .cin(c4i), .sub(s4i), .out_valid(ov4), .out_ready(or4), .sum(s4),
    .cout(co4), .ovf(of4), .zero(z4));

  cla_pipe #(.WIDTH(64), .GROUP(8), .STAGES(2)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
    .cin(c8i), .sub(s8i), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(of8), .zero(z8));

  // Reference: {cout, ovf, zero, sum} from plain wide addition
  function automatic logic [66:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic s, input logic c);
    logic [64:0] full;
    logic [63:0] mask, yy, r, xx;
    logic        co, of;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    xx   = x & mask;
    yy   = (s ? ~y : y) & mask;
    full = {1'b0, xx} + {1'b0, yy} + 65'(s | c);
    r    = full[63:0] & mask;
    co   = full[w];
    of   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
    return {co, of, (r == 64'd0), r};
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic ts, output logic [15:0] rs, output logic rc,
                        output logic ro, output logic rz, output int lat);
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    rs = sum; rc = cout; ro = ovf; rz = zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v1 = 0; a1 = '0; b1 = '0; c1i = 0; s1i = 0; or1 = 1;
    v4 = 0; a4 = '0; b4 = '0; c4i = 0; s4i = 0; or4 = 1;
    v8 = 0; a8 = '0; b8 = '0; c8i = 0; s8i = 0; or8 = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({sum, cout, ovf, zero} !== 19'd0) begin errors++; $display("FAIL reset_outputs got sum %h c%b o%b z%b exp all 0", sum, cout, ovf, zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    logic [15:0] s; logic c, o, z; int lat;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, s, c, o, z, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
    checks++; if ({s, c, o, z} !== {16'h5555, 3'b000}) begin errors++; $display("FAIL add_basic got %h c%b o%b z%b exp 5555 c0 o0 z0", s, c, o, z); end
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, s, c, o, z, lat);
    checks++; if ({s, c, o, z} !== {16'h8000, 3'b010}) begin errors++; $display("FAIL add_cin_ovf got %h c%b o%b z%b exp 8000 c0 o1 z0", s, c, o, z); end
  endtask

  task automatic test_carry();
    logic [15:0] s; logic c, o, z; int lat;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, o, z, lat);
    checks++; if ({s, c, o, z} !== {16'h0100, 3'b000}) begin errors++; $display("FAIL carry_boundary got %h c%b o%b z%b exp 0100 c0 o0 z0", s, c, o, z); end
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, z, lat);
    checks++; if ({s, c, o, z} !== {16'h0000, 3'b101}) begin errors++; $display("FAIL carry_wrap got %h c%b o%b z%b exp 0000 c1 o0 z1", s, c, o, z); end
  endtask

  task automatic test_sub();
    logic [15:0] s; logic c, o, z; int lat;
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, z, lat);
    checks++; if ({s, c, o, z} !== {16'h7FFF, 3'b110}) begin errors++; $display("FAIL sub_ovf got %h c%b o%b z%b exp 7fff c1 o1 z0", s, c, o, z); end
    run_op(16'h0005, 16'h0005, 1'b0, 1'b1, s, c, o, z, lat);
    checks++; if ({s, c, o, z} !== {16'h0000, 3'b101}) begin errors++; $display("FAIL sub_zero got %h c%b o%b z%b exp 0000 c1 o0 z1", s, c, o, z); end
    run_op(16'h0005, 16'h0005, 1'b1, 1'b1, s, c, o, z, lat);
    checks++; if ({s, c, o, z} !== {16'h0000, 3'b101}) begin errors++; $display("FAIL sub_cin_ignored got %h c%b o%b z%b exp 0000 c1 o0 z1", s, c, o, z); end
  endtask

  task automatic test_stall();
    logic [15:0] got[$];
    logic [15:0] held;
    logic        have_held = 1'b0;
    logic        acc;
    int          sent = 0;
    int          stalls = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid  = (sent < 4);
      a = 16'(sent); b = 16'(sent + 1); cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        stalls++;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
        if (have_held) begin
          checks++; if (sum !== held) begin errors++; $display("FAIL stall_stable got %h exp %h", sum, held); end
        end
        held = sum; have_held = 1'b1;
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(sum);
      @(posedge clk);
      if (acc) sent++;
      #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    checks++; if (stalls != 3) begin errors++; $display("FAIL stall_cycles got %0d exp 3", stalls); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL stall_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== 16'(2*i + 1)) begin errors++; $display("FAIL stall_order idx %0d got %h exp %h", i, got[i], 16'(2*i + 1)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic c, o, z; int lat;
    int seen = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'd1; b = 16'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'd2; b = 16'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inflight got %b exp 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b exp 0", out_valid); end
    checks++; if (sum !== 16'd0) begin errors++; $display("FAIL rstmid_sum got %h exp 0000", sum); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_ghost got %0d valid cycles exp 0", seen); end
    run_op(16'd3, 16'd4, 1'b0, 1'b0, s, c, o, z, lat);
    checks++; if (s !== 16'd7 || lat != 2) begin errors++; $display("FAIL rstmid_resume got %h lat %0d exp 0007 lat 2", s, lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] av[4], bv[4], ev[4];
    logic        sv[4], cv[4], ec[4];
    int n = 0, first = -1, last = -1;
    av = '{16'h0010, 16'h0010, 16'hFFF0, 16'h0003};
    bv = '{16'h0003, 16'h0003, 16'h0020, 16'h0010};
    sv = '{1'b0, 1'b1, 1'b0, 1'b1};
    cv = '{1'b0, 1'b0, 1'b1, 1'b0};
    ev = '{16'h0013, 16'h000D, 16'h0011, 16'hFFF3};
    ec = '{1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 4) begin
        in_valid = 1'b1; a = av[cyc]; b = bv[cyc]; sub = sv[cyc]; cin = cv[cyc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        if (n < 4) begin
          checks++; if ({cout, sum} !== {ec[n], ev[n]}) begin errors++; $display("FAIL b2b_result idx %0d got %h c%b exp %h c%b", n, sum, cout, ev[n], ec[n]); end
        end
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    checks++; if (n != 4 || last - first != 3) begin errors++; $display("FAIL b2b_throughput got %0d results over %0d cycles exp 4 over 3", n, last - first); end
  endtask

  task automatic test_sweep();
    logic [66:0] q1[$], q4[$], q8[$];
    logic [66:0] e;
    int n1 = 0, n4 = 0, n8 = 0;
    logic drain;
    for (int cyc = 0; cyc < 430; cyc++) begin
      drain = (cyc >= 400);
      @(posedge clk); #1;
      v1 = !drain && ($urandom_range(0, 3) != 0); or1 = drain || ($urandom_range(0, 3) != 0);
      a1 = 16'($urandom); b1 = 16'($urandom); c1i = 1'($urandom); s1i = 1'($urandom);
      v4 = !drain && ($urandom_range(0, 3) != 0); or4 = drain || ($urandom_range(0, 3) != 0);
      a4 = $urandom; b4 = $urandom; c4i = 1'($urandom); s4i = 1'($urandom);
      v8 = !drain && ($urandom_range(0, 3) != 0); or8 = drain || ($urandom_range(0, 3) != 0);
      a8 = {$urandom, $urandom}; b8 = {$urandom, $urandom}; c8i = 1'($urandom); s8i = 1'($urandom);
      if (cyc < 8) begin a8 = 64'hFFFF_FFFF_FFFF_FFFF; b8 = 64'(cyc); end
      @(negedge clk);
      if (ov1 && or1) begin
        checks++; n1++;
        if (q1.size() == 0) begin errors++; $display("FAIL sweep16 got extra sum %h exp none", s1); end
        else begin
          e = q1.pop_front();
          if ({co1, of1, z1, 48'd0, s1} !== e) begin errors++; $display("FAIL sweep16 got %h c%b o%b z%b exp %h c%b o%b z%b", s1, co1, of1, z1, e[15:0], e[66], e[65], e[64]); end
        end
      end
      if (v1 && r1) q1.push_back(model(16, 64'(a1), 64'(b1), s1i, c1i));
      if (ov4 && or4) begin
        checks++; n4++;
        if (q4.size() == 0) begin errors++; $display("FAIL sweep32 got extra sum %h exp none", s4); end
        else begin
          e = q4.pop_front();
          if ({co4, of4, z4, 32'd0, s4} !== e) begin errors++; $display("FAIL sweep32 got %h c%b o%b z%b exp %h c%b o%b z%b", s4, co4, of4, z4, e[31:0], e[66], e[65], e[64]); end
        end
      end
      if (v4 && r4) q4.push_back(model(32, 64'(a4), 64'(b4), s4i, c4i));
      if (ov8 && or8) begin
        checks++; n8++;
        if (q8.size() == 0) begin errors++; $display("FAIL sweep64 got extra sum %h exp none", s8); end
        else begin
          e = q8.pop_front();
          if ({co8, of8, z8, s8} !== e) begin errors++; $display("FAIL sweep64 got %h c%b o%b z%b exp %h c%b o%b z%b", s8, co8, of8, z8, e[63:0], e[66], e[65], e[64]); end
        end
      end
      if (v8 && r8) q8.push_back(model(64, a8, b8, s8i, c8i));
    end
    checks++; if (q1.size() != 0 || n1 < 50) begin errors++; $display("FAIL sweep16_drain got %0d pending %0d delivered exp 0 pending", q1.size(), n1); end
    checks++; if (q4.size() != 0 || n4 < 50) begin errors++; $display("FAIL sweep32_drain got %0d pending %0d delivered exp 0 pending", q4.size(), n4); end
    checks++; if (q8.size() != 0 || n8 < 50) begin errors++; $display("FAIL sweep64_drain got %0d pending %0d delivered exp 0 pending", q8.size(), n8); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
